pc_word_sequencer: RTL

Program-counter sequencer for the IF stage of the pipelined SAD datapath. Holds the byte-addressed PC, selects the next PC (sequential, branch, jump, jump-register), rebuilds jump targets from the 26-bit instruction field, and drives the instruction memory with a word index (PC >> 2). It inverts the decode-side jump shift: it turns byte addresses into word addresses. It also inserts a squash bubble after every redirect and counts redirects.

---
 rtl/pc_word_sequencer_if.sv | 44 ++++
 rtl/pc_word_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pc_word_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_word_sequencer_if
//  Description : Bundle between the IF-stage control (redirect requests and
//                stall) and the PC word sequencer (PC, fetch address, status).
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_word_sequencer_if #(
  parameter int ADDR_W = 10
);
  // Requests from the pipeline control towards the sequencer
  logic              stall;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic              jump_en;
  logic [25:0]       jump_field;
  logic              jump_reg;
  logic [31:0]       reg_target;

  // Sequencer results towards the fetch stage and the rest of the pipe
  logic [31:0]       pc_byte;
  logic [31:0]       pc_plus4;
  logic [ADDR_W-1:0] imem_word_addr;
  logic              fetch_valid;
  logic [15:0]       redirect_cnt;
  logic              misalign;

  // Pipeline control side: issues requests, observes the PC
  modport master (
    output stall, branch_taken, branch_target, jump_en, jump_field,
           jump_reg, reg_target,
    input  pc_byte, pc_plus4, imem_word_addr, fetch_valid, redirect_cnt,
           misalign
  );

  // Sequencer side
  modport slave (
    input  stall, branch_taken, branch_target, jump_en, jump_field,
           jump_reg, reg_target,
    output pc_byte, pc_plus4, imem_word_addr, fetch_valid, redirect_cnt,
           misalign
  );
endinterface
`default_nettype wire

// File: rtl/pc_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_word_sequencer
//  Description : IF-stage program counter. Holds the byte PC, picks the next
//                PC (jr > j > branch > +4), rebuilds jump targets from the
//                26-bit field, drives instruction memory with PC >> 2, marks
//                the wrong-path fetch after each redirect and counts redirects.
//  Options     : PC_MISALIGN_TRAP_EN - misaligned branch/jr targets load
//                TRAP_VECTOR and pulse misalign; otherwise the low two target
//                bits are cleared and misalign is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_word_sequencer #(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0180
) (
  input  wire logic            clk,
  input  wire logic            rst,
  pc_word_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [15:0] r_cnt;
  logic        r_fetch_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_target;
  logic [31:0] w_raw_target;
  logic [31:0] w_next_target;
  logic        w_redirect;
  logic        w_data_sel;
  logic        w_lo_bad;
  logic        w_trap;

  // Next-PC candidates and the prioritised redirect target
  always_comb begin
    w_pc_plus4    = r_pc + 32'd4;
    w_jump_target = {r_pc[31:28], bus.jump_field, 2'b00};
    w_redirect    = bus.jump_reg | bus.jump_en | bus.branch_taken;
    // A data-sourced target (jr or branch) is the only kind that can be
    // misaligned; the jump target is built with 2'b00 at the bottom.
    w_data_sel    = bus.jump_reg | (~bus.jump_en & bus.branch_taken);
    if (bus.jump_reg) begin
      w_raw_target = bus.reg_target;
    end else if (bus.jump_en) begin
      w_raw_target = w_jump_target;
    end else begin
      w_raw_target = bus.branch_target;
    end
    w_lo_bad = w_data_sel & (w_raw_target[1:0] != 2'b00);
`ifdef PC_MISALIGN_TRAP_EN
    w_trap        = w_lo_bad;
    w_next_target = w_trap ? TRAP_VECTOR : w_raw_target;
`else
    w_trap        = 1'b0;
    w_next_target = {w_raw_target[31:2], 2'b00};
`endif
  end

  // Sequencer FSM: PC, state, fetch-valid flag and saturating redirect count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_cnt         <= 16'd0;
      r_fetch_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          // First fetch after reset is issued from RESET_PC unchanged
          r_state       <= ST_RUN;
          r_fetch_valid <= 1'b1;
        end
        ST_RUN, ST_BUBBLE: begin
          if (!bus.stall) begin
            if (w_redirect) begin
              r_pc          <= w_next_target;
              r_state       <= ST_BUBBLE;
              r_fetch_valid <= 1'b0;
              if (r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
              end
            end else begin
              r_pc          <= w_pc_plus4;
              r_state       <= ST_RUN;
              r_fetch_valid <= 1'b1;
            end
          end
        end
        default: begin
          r_state       <= ST_BOOT;
          r_fetch_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic r_misalign;

  // One-cycle pulse alongside the cycle the PC shows TRAP_VECTOR
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= (r_state != ST_BOOT) & ~bus.stall & w_redirect & w_trap;
    end
  end

  assign bus.misalign = r_misalign;
`else
  // Trap logic is absent: the vector and the trap decision have no sink
  localparam logic [31:0] c_unused_trap = TRAP_VECTOR;
  logic w_unused_trap;
  assign w_unused_trap = w_trap ^ w_lo_bad ^ (|c_unused_trap);
  assign bus.misalign  = 1'b0;
`endif

  assign bus.pc_byte        = r_pc;
  assign bus.pc_plus4       = w_pc_plus4;
  assign bus.imem_word_addr = r_pc[ADDR_W+1:2];
  assign bus.fetch_valid    = r_fetch_valid;
  assign bus.redirect_cnt   = r_cnt;

endmodule
`default_nettype wire
